// File: rtl/y_pkg.sv
// Shared opcode/ALU constants, FSM state and decoded-control bundle for y_pc_seq.
package y_pkg;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_ADDI = 7'h13;
    localparam logic [6:0] OP_ST   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_COMMIT,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic [2:0] op;
        logic       is_br;
        logic       is_jal;
        logic       known;
    } ctrl_t;

endpackage

// File: rtl/y_ctrl_dec.sv
// Combinational opcode/funct3 to datapath-control decoder.
module y_ctrl_dec
    import y_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o       = '0;
        ctrl_o.op    = ALU_ADD;
        ctrl_o.known = 1'b1;
        case (opcode_i)
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.op        = (funct3_i == 3'b110) ? ALU_AND : ALU_ADD;
            end
            OP_LD: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.mem2reg   = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_ST: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_BR: begin
                ctrl_o.op    = ALU_SUB;
                ctrl_o.is_br = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.is_jal    = 1'b1;
            end
            default: ctrl_o.known = 1'b0;
        endcase
    end

endmodule

// File: rtl/y_pc_seq.sv
// PC register and 3-cycle FETCH/EXEC/COMMIT control sequencer.
// Y_PC_SEQ_ILLEGAL_TRAP_EN: unknown opcode in COMMIT sets illegal and halts without advancing.
module y_pc_seq
    import y_pkg::*;
#(
    parameter logic [31:0] ENTRY_PC = 32'h0000_0028,
    parameter int          MAX_INS  = 43
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ins,
    input  logic [31:0] imm,
    input  logic [31:0] jtarget,
    input  logic        zero,
    output logic [31:0] pc,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem2reg,
    output logic [2:0]  op,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] ins_count
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_INS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, npc;
    logic [9:0]  ins_q, ins_d;   // only {funct3, opcode} are needed downstream
    logic [15:0] cnt_q, cnt_d;
    logic        run_ok_q;
    ctrl_t       dec;

    logic unused_ok;
    assign unused_ok = ^{ins[31:15], ins[11:7], imm[31], jtarget[31:30]};

    y_ctrl_dec u_dec (
        .opcode_i (ins_q[6:0]),
        .funct3_i (ins_q[9:7]),
        .ctrl_o   (dec)
    );

    always_comb begin
        if (dec.is_br && zero)
            npc = pc_q + {imm[30:0], 1'b0};
        else if (dec.is_jal)
            npc = pc_q + {jtarget[29:0], 2'b00};
        else
            npc = pc_q + 32'd4;
    end

`ifdef Y_PC_SEQ_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        cnt_d   = cnt_q;
`ifdef Y_PC_SEQ_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                // run_ok_q blocks a start coinciding with reset release
                if (start && run_ok_q) begin
                    pc_d    = ENTRY_PC;
                    cnt_d   = '0;
                    state_d = S_FETCH;
`ifdef Y_PC_SEQ_ILLEGAL_TRAP_EN
                    illegal_d = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                ins_d   = {ins[14:12], ins[6:0]};
                state_d = S_EXEC;
            end
            S_EXEC: state_d = S_COMMIT;
            S_COMMIT: begin
`ifdef Y_PC_SEQ_ILLEGAL_TRAP_EN
                if (!dec.known) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else
`endif
                begin
                    pc_d    = npc;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = (cnt_d == MAX_CNT) ? S_HALT : S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ins_q    <= '0;
            cnt_q    <= '0;
            run_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            cnt_q    <= cnt_d;
            run_ok_q <= 1'b1;
        end
    end

`ifdef Y_PC_SEQ_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Controls are a pure function of state so reset clears them without a clock.
    always_comb begin
        reg_write = 1'b0;
        alu_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem2reg   = 1'b0;
        op        = ALU_ADD;
        if (state_q == S_EXEC || state_q == S_COMMIT) begin
            alu_src  = dec.alu_src;
            mem_read = dec.mem_read;
            mem2reg  = dec.mem2reg;
            op       = dec.op;
            if (state_q == S_COMMIT) begin
                reg_write = dec.reg_write;
                mem_write = dec.mem_write;
            end
        end
    end

    assign pc        = pc_q;
    assign ins_count = cnt_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_COMMIT);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_y_pc_seq.sv
// Directed plus randomized bench for y_pc_seq against an instruction-level reference model.
module tb_y_pc_seq;

    localparam int          MAXI = 3;
    localparam logic [31:0] EPC  = 32'h0000_0028;

    logic        clk = 1'b0;
    logic        rst_n, start, zero;
    logic [31:0] ins, imm, jtarget, pc;
    logic        reg_write, alu_src, mem_read, mem_write, mem2reg;
    logic [2:0]  op;
    logic        busy, halted, illegal;
    logic [15:0] ins_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mpc;
    int          mcnt;
    bit          mill, mhalt;

    wire [7:0] ctl = {reg_write, alu_src, mem_read, mem_write, mem2reg, op};

    y_pc_seq #(.ENTRY_PC(EPC), .MAX_INS(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .imm(imm),
        .jtarget(jtarget), .zero(zero), .pc(pc), .reg_write(reg_write),
        .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem2reg(mem2reg), .op(op), .busy(busy), .halted(halted),
        .illegal(illegal), .ins_count(ins_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit known_op(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F};
    endfunction

    // {reg_write, alu_src, mem_read, mem_write, mem2reg, op}
    function automatic logic [7:0] ref_ctrl(input logic [31:0] i, input bit commit);
        logic rw, as, mr, mw, m2r;
        logic [2:0] o;
        rw = 0; as = 0; mr = 0; mw = 0; m2r = 0; o = 3'b010;
        case (i[6:0])
            7'h33: begin rw = 1; o = (i[14:12] == 3'b110) ? 3'b001 : 3'b010; end
            7'h03: begin rw = 1; as = 1; mr = 1; m2r = 1; end
            7'h13: begin rw = 1; as = 1; end
            7'h23: begin mw = 1; as = 1; end
            7'h63: o = 3'b110;
            7'h6F: begin rw = 1; as = 1; end
            default: ;
        endcase
        if (!commit) begin rw = 0; mw = 0; end
        return {rw, as, mr, mw, m2r, o};
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] i,
                                             input logic [31:0] im, input logic [31:0] jt,
                                             input logic z);
        if (i[6:0] == 7'h63 && z) return p + im * 32'd2;
        if (i[6:0] == 7'h6F)      return p + jt * 32'd4;
        return p + 32'd4;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mpc = EPC; mcnt = 0; mill = 0; mhalt = 0;
        chk("start_pc", pc, mpc);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cnt", 32'(ins_count), 32'd0);
        chk("start_ill", 32'(illegal), 32'd0);
    endtask

    task automatic run_ins(input logic [31:0] iv, input logic [31:0] imv,
                           input logic [31:0] jtv, input logic zv, input logic hold);
        ins = iv; imm = $urandom; jtarget = $urandom; zero = 1'($urandom); start = hold;
        chk("fetch_ctl", 32'(ctl), 32'h02);
        chk("fetch_pc", pc, mpc);
        @(posedge clk); #1;
        ins = $urandom;
        chk("exec_ctl", 32'(ctl), 32'(ref_ctrl(iv, 0)));
        chk("exec_pc", pc, mpc);
        imm = imv; jtarget = jtv; zero = zv;
        @(posedge clk); #1;
        chk("commit_ctl", 32'(ctl), 32'(ref_ctrl(iv, 1)));
        chk("commit_pc", pc, mpc);
        @(posedge clk); #1;
        imm = $urandom; jtarget = $urandom; zero = 1'($urandom); start = 1'b0;
`ifdef Y_PC_SEQ_ILLEGAL_TRAP_EN
        if (!known_op(iv)) begin
            mill = 1; mhalt = 1;
        end else
`endif
        begin
            mpc = ref_next(mpc, iv, imv, jtv, zv);
            mcnt++;
            mhalt = (mcnt == MAXI);
        end
        chk("next_pc", pc, mpc);
        chk("next_cnt", 32'(ins_count), 32'(mcnt));
        chk("next_halted", 32'(halted), 32'(mhalt));
        chk("next_busy", 32'(busy), 32'(!mhalt));
        chk("next_ill", 32'(illegal), 32'(mill));
        chk("post_ctl", 32'(ctl), 32'h02);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        logic [6:0]  opc [7] = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h0B};
        r = $urandom;
        r[6:0] = opc[$urandom_range(0, 6)];
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; ins = '0; imm = '0; jtarget = '0; zero = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ctl", 32'(ctl), 32'h02);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_cnt", 32'(ins_count), 32'd0);

        // start coinciding with reset release is ignored
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_at_rel_busy", 32'(busy), 32'd0);
        chk("start_at_rel_pc", pc, 32'h0);
        @(posedge clk); #1;

        // add, beq not taken, addi
        do_start();
        run_ins(32'h0020_81B3, 32'd8, 32'd0, 1'b0, 1'b0);
        run_ins(32'h0020_8063, 32'd8, 32'd0, 1'b0, 1'b0);
        run_ins(32'h0010_0093, 32'd0, 32'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("halt_hold_pc", pc, mpc);
        chk("halt_hold_halted", 32'(halted), 32'd1);
        chk("halt_hold_cnt", 32'(ins_count), 32'd3);

        // beq taken, addi with start held (ignored), and-form R-type
        do_start();
        run_ins(32'h0020_8063, 32'd8, 32'd0, 1'b1, 1'b0);
        run_ins(32'h0010_0093, 32'd0, 32'd0, 1'b0, 1'b1);
        run_ins(32'h0020_E1B3, 32'd0, 32'd0, 1'b0, 1'b0);

        // jal forward, jal backward, store
        do_start();
        run_ins(32'h0000_006F, 32'd0, 32'd6, 1'b0, 1'b0);
        run_ins(32'h0000_006F, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_ins(32'h0020_A023, 32'd0, 32'd0, 1'b0, 1'b0);

        // jump to 0xFFFF_FFFC, load wraps to 0, then an all-zero opcode
        do_start();
        run_ins(32'h0000_006F, 32'd0, 32'hFFFF_FFF5, 1'b0, 1'b0);
        run_ins(32'h0000_A103, 32'd0, 32'd0, 1'b0, 1'b0);
        run_ins(32'h0000_0000, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("illegal_hold_pc", pc, mpc);

        // reset mid-EXEC with a pending write
        do_start();
        ins = 32'h0020_81B3;
        @(posedge clk); #1;
        chk("pre_rst_ctl", 32'(ctl), 32'(ref_ctrl(32'h0020_81B3, 0)));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", 32'(ctl), 32'h02);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_cnt", 32'(ins_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_write", 32'({reg_write, mem_write}), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("after_rst_idle", 32'(busy), 32'd0);
        chk("after_rst_wr", 32'({reg_write, mem_write}), 32'd0);

        // randomized programs
        for (int r = 0; r < 20; r++) begin
            do_start();
            while (!mhalt)
                run_ins(rand_ins(), 32'($urandom_range(0, 63)) - 32'd32,
                        32'($urandom_range(0, 31)) - 32'd16, 1'($urandom), 1'($urandom));
            @(posedge clk); #1;
            chk("rand_halt_pc", pc, mpc);
            chk("rand_halted", 32'(halted), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
